// File: rtl/uart_monitor_if.sv
// uart_monitor_if
//   Groups every non-clock signal of the boot/debug monitor into one bundle.
//   UART side : received, rx_byte, is_transmitting, transmit, tx_byte
//   RAM side  : raddr, waddr, dwrite, write_en, dread
//   CPU side  : cpu_start, cpu_startaddr, cpu_halted, cpu_raddr, cpu_waddr,
//               cpu_dwrite, cpu_write_en, cpu_tx_byte, cpu_transmit, cpu_received
//   Status    : busy
//   master = the monitor itself; slave = the UART/RAM/CPU environment.
interface uart_monitor_if #(
  parameter int addr_width = 9
);
  logic                  received;
  logic [7:0]            rx_byte;
  logic                  is_transmitting;
  logic                  transmit;
  logic [7:0]            tx_byte;
  logic [addr_width-1:0] raddr;
  logic [addr_width-1:0] waddr;
  logic [7:0]            dwrite;
  logic                  write_en;
  logic [7:0]            dread;
  logic                  cpu_start;
  logic [addr_width-1:0] cpu_startaddr;
  logic                  cpu_halted;
  logic [addr_width-1:0] cpu_raddr;
  logic [addr_width-1:0] cpu_waddr;
  logic [7:0]            cpu_dwrite;
  logic                  cpu_write_en;
  logic [7:0]            cpu_tx_byte;
  logic                  cpu_transmit;
  logic                  cpu_received;
  logic                  busy;

  modport master (
    input  received, rx_byte, is_transmitting, dread, cpu_halted,
           cpu_raddr, cpu_waddr, cpu_dwrite, cpu_write_en, cpu_tx_byte, cpu_transmit,
    output transmit, tx_byte, raddr, waddr, dwrite, write_en,
           cpu_start, cpu_startaddr, cpu_received, busy
  );

  modport slave (
    output received, rx_byte, is_transmitting, dread, cpu_halted,
           cpu_raddr, cpu_waddr, cpu_dwrite, cpu_write_en, cpu_tx_byte, cpu_transmit,
    input  transmit, tx_byte, raddr, waddr, dwrite, write_en,
           cpu_start, cpu_startaddr, cpu_received, busy
  );
endinterface

// File: rtl/uart_monitor.sv
// uart_monitor
//   Boot/debug sequencer sitting between the UART, the shared RAM and the cpu.
//   While the cpu is idle the monitor owns RAM and UART and decodes host
//   commands: 'L' hi lo N data... (load), 'D' hi lo N (dump), 'R' hi lo (run).
//   On run it pulses cpu_start and hands RAM/UART to the cpu until cpu_halted.
// Ports
//   clk  : single clock, everything on posedge
//   rst  : synchronous active-high reset
//   bus  : uart_monitor_if.master (UART, RAM, CPU and busy signals)
module uart_monitor #(
  parameter int addr_width = 9
) (
  input logic            clk,
  input logic            rst,
  uart_monitor_if.master bus
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] RPL_OK   = 8'h2E;
  localparam logic [7:0] RPL_HALT = 8'h48;
  localparam logic [7:0] RPL_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADRH, ADRL, CNT, LOAD, RDADDR, RDWAIT, TX, TXGAP, START, RUN
  } state_t;

  typedef logic [addr_width-1:0] addr_t;

  state_t     state, state_nxt;
  logic [7:0] cmd, cmd_nxt;
  logic [7:0] addr_hi, addr_hi_nxt;
  addr_t      addr, addr_nxt;
  logic [8:0] cnt, cnt_nxt;

  logic       transmit_r, transmit_nxt;
  logic [7:0] tx_byte_r, tx_byte_nxt;
  addr_t      raddr_r, raddr_nxt;
  addr_t      waddr_r, waddr_nxt;
  logic [7:0] dwrite_r, dwrite_nxt;
  logic       write_en_r, write_en_nxt;
  logic       cpu_start_r, cpu_start_nxt;
  addr_t      cpu_startaddr_r, cpu_startaddr_nxt;

  logic       run;

  // Address is {hi, lo} truncated to the RAM width; surplus hi bits drop out.
  function automatic addr_t make_addr(input logic [7:0] hi, input logic [7:0] lo);
    return addr_t'({hi, lo});
  endfunction

  // A count byte of zero stands for 256, hence the 9-bit counter.
  function automatic logic [8:0] decode_count(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cmd             <= 8'd0;
      addr_hi         <= 8'd0;
      addr            <= '0;
      cnt             <= 9'd0;
      transmit_r      <= 1'b0;
      tx_byte_r       <= 8'd0;
      raddr_r         <= '0;
      waddr_r         <= '0;
      dwrite_r        <= 8'd0;
      write_en_r      <= 1'b0;
      cpu_start_r     <= 1'b0;
      cpu_startaddr_r <= '0;
    end else begin
      state           <= state_nxt;
      cmd             <= cmd_nxt;
      addr_hi         <= addr_hi_nxt;
      addr            <= addr_nxt;
      cnt             <= cnt_nxt;
      transmit_r      <= transmit_nxt;
      tx_byte_r       <= tx_byte_nxt;
      raddr_r         <= raddr_nxt;
      waddr_r         <= waddr_nxt;
      dwrite_r        <= dwrite_nxt;
      write_en_r      <= write_en_nxt;
      cpu_start_r     <= cpu_start_nxt;
      cpu_startaddr_r <= cpu_startaddr_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cmd_nxt           = cmd;
    addr_hi_nxt       = addr_hi;
    addr_nxt          = addr;
    cnt_nxt           = cnt;
    transmit_nxt      = 1'b0;
    tx_byte_nxt       = tx_byte_r;
    raddr_nxt         = raddr_r;
    waddr_nxt         = waddr_r;
    dwrite_nxt        = dwrite_r;
    write_en_nxt      = 1'b0;
    cpu_start_nxt     = 1'b0;
    cpu_startaddr_nxt = cpu_startaddr_r;

    unique case (state)
      IDLE: begin
        if (bus.received) begin
          if (bus.rx_byte == CMD_LOAD || bus.rx_byte == CMD_DUMP || bus.rx_byte == CMD_RUN) begin
            cmd_nxt   = bus.rx_byte;
            state_nxt = ADRH;
          end else begin
            // cmd must not read as DUMP, or TXGAP would resume a dump.
            cmd_nxt     = RPL_ERR;
            tx_byte_nxt = RPL_ERR;
            state_nxt   = TX;
          end
        end
      end
      ADRH: begin
        if (bus.received) begin
          addr_hi_nxt = bus.rx_byte;
          state_nxt   = ADRL;
        end
      end
      ADRL: begin
        if (bus.received) begin
          addr_nxt = make_addr(addr_hi, bus.rx_byte);
          if (cmd == CMD_RUN) begin
            cpu_startaddr_nxt = make_addr(addr_hi, bus.rx_byte);
            state_nxt         = START;
          end else begin
            state_nxt = CNT;
          end
        end
      end
      CNT: begin
        if (bus.received) begin
          cnt_nxt   = decode_count(bus.rx_byte);
          state_nxt = (cmd == CMD_LOAD) ? LOAD : RDADDR;
        end
      end
      LOAD: begin
        if (bus.received) begin
          write_en_nxt = 1'b1;
          waddr_nxt    = addr;
          dwrite_nxt   = bus.rx_byte;
          addr_nxt     = addr + addr_t'(1);
          cnt_nxt      = cnt - 9'd1;
          if (cnt == 9'd1) begin
            tx_byte_nxt = RPL_OK;
            state_nxt   = TX;
          end
        end
      end
      RDADDR: begin
        raddr_nxt = addr;
        addr_nxt  = addr + addr_t'(1);
        cnt_nxt   = cnt - 9'd1;
        state_nxt = RDWAIT;
      end
      RDWAIT: state_nxt = TX;
      TX: begin
        // raddr is held here, so dread stays valid while the UART is busy.
        if (cmd == CMD_DUMP) tx_byte_nxt = bus.dread;
        if (!bus.is_transmitting) begin
          transmit_nxt = 1'b1;
          state_nxt    = TXGAP;
        end
      end
      TXGAP: begin
        // One dead cycle lets the UART raise is_transmitting before we look again.
        state_nxt = (cmd == CMD_DUMP && cnt != 9'd0) ? RDADDR : IDLE;
      end
      START: begin
        cpu_start_nxt = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        if (bus.cpu_halted) begin
          tx_byte_nxt = RPL_HALT;
          state_nxt   = TX;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership mux: the cpu drives RAM and UART only while in RUN.
  assign run               = (state == RUN);
  assign bus.transmit      = run ? bus.cpu_transmit : transmit_r;
  assign bus.tx_byte       = run ? bus.cpu_tx_byte  : tx_byte_r;
  assign bus.raddr         = run ? bus.cpu_raddr    : raddr_r;
  assign bus.waddr         = run ? bus.cpu_waddr    : waddr_r;
  assign bus.dwrite        = run ? bus.cpu_dwrite   : dwrite_r;
  assign bus.write_en      = run ? bus.cpu_write_en : write_en_r;
  assign bus.cpu_received  = run & bus.received;
  assign bus.cpu_start     = cpu_start_r;
  assign bus.cpu_startaddr = cpu_startaddr_r;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_monitor.sv
// tb_uart_monitor
//   Bench for uart_monitor: models the UART busy timer and a synchronous RAM,
//   keeps expected transmits and writes in scoreboard queues and checks them
//   as the DUT produces them.
module tb_uart_monitor;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_monitor_if #(.addr_width(AW)) bus ();
  uart_monitor #(.addr_width(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int tx_count = 0;
  int start_count = 0;
  logic start_prev = 1'b0;
  logic [AW-1:0] last_start_addr;
  logic chk_wr_timing = 1'b1;
  logic hold_busy = 1'b0;
  int tx_timer = 0;

  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  logic [7:0] tx_q [$];
  logic [AW+7:0] wr_q [$];
  logic [7:0] exp_tx;
  logic [AW+7:0] exp_wr;

  always @(posedge clk) cyc <= cyc + 1;

  // UART busy model and synchronous RAM (read data one clock after raddr).
  always @(posedge clk) begin
    if (rst) tx_timer <= 0;
    else if (bus.transmit) tx_timer <= 4;
    else if (tx_timer != 0) tx_timer <= tx_timer - 1;
    if (bus.write_en) ram[bus.waddr] <= bus.dwrite;
    bus.dread <= ram[bus.raddr];
  end
  assign bus.is_transmitting = hold_busy || (tx_timer != 0);

  // Scoreboard side: every transmit, write and start pulse is checked here.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.transmit) begin
        tx_count++;
        checks++;
        if (bus.is_transmitting) begin
          errors++;
          $display("FAIL tx_while_busy: transmit=1 with is_transmitting=1, want no transmit");
        end else if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got %02h, want no transmit", bus.tx_byte);
        end else begin
          exp_tx = tx_q.pop_front();
          if (bus.tx_byte !== exp_tx) begin
            errors++;
            $display("FAIL tx_byte: got %02h, want %02h", bus.tx_byte, exp_tx);
          end
        end
      end
      if (bus.write_en) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_extra: got %03h=%02h, want no write", bus.waddr, bus.dwrite);
        end else begin
          exp_wr = wr_q.pop_front();
          if ({bus.waddr, bus.dwrite} !== exp_wr || (chk_wr_timing && cyc != last_rx_cyc + 1)) begin
            errors++;
            $display("FAIL wr: got %03h=%02h at +%0d, want %03h=%02h at +1",
                     bus.waddr, bus.dwrite, cyc - last_rx_cyc, exp_wr[AW+7:8], exp_wr[7:0]);
          end
        end
      end
      if (bus.cpu_start) begin
        start_count++;
        last_start_addr = bus.cpu_startaddr;
        checks++;
        if (start_prev) begin
          errors++;
          $display("FAIL start_width: cpu_start high 2 cycles, want 1");
        end
      end
      start_prev = bus.cpu_start;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_byte = b;
    bus.received = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    bus.received = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    logic [AW-1:0] aa;
    aa = AW'(a);
    wr_q.push_back({aa, d});
    ref_mem[aa] = d;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (tx_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.transmit !== 1'b0 || bus.write_en !== 1'b0 ||
        bus.cpu_start !== 1'b0 || bus.cpu_received !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b tx=%b we=%b start=%b crx=%b, want all 0",
               bus.busy, bus.transmit, bus.write_en, bus.cpu_start, bus.cpu_received);
    end
    checks++;
    if (bus.raddr !== '0 || bus.waddr !== '0 || bus.dwrite !== 8'h00 ||
        bus.tx_byte !== 8'h00 || bus.cpu_startaddr !== '0) begin
      errors++;
      $display("FAIL reset_data: raddr=%h waddr=%h dwrite=%h tx_byte=%h startaddr=%h, want all 0",
               bus.raddr, bus.waddr, bus.dwrite, bus.tx_byte, bus.cpu_startaddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load;
    push_wr(12'h010, 8'hAA); push_wr(12'h011, 8'hBB); push_wr(12'h012, 8'hCC);
    tx_q.push_back(8'h2E);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_drain(200);
    checks++;
    if (tx_q.size() != 0 || wr_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done: pending tx=%0d wr=%0d busy=%b, want 0 0 0", tx_q.size(), wr_q.size(), bus.busy);
    end
  endtask

  task automatic test_dump;
    for (int i = 0; i < 3; i++) tx_q.push_back(ref_mem[12'h010 + i]);
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    wait_drain(300);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL dump3: pending tx=%0d, want 0", tx_q.size());
    end
  endtask

  task automatic test_wrap;
    push_wr(12'h1FF, 8'h11); push_wr(12'h000, 8'h22);
    tx_q.push_back(8'h2E);
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    wait_drain(200);
    push_wr(12'h1FF, 8'h33);
    tx_q.push_back(8'h2E);
    send_byte(8'h4C); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h33);
    wait_drain(200);
    tx_q.push_back(ref_mem[12'h1FF]); tx_q.push_back(ref_mem[12'h000]);
    send_byte(8'h44); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h02);
    wait_drain(300);
    checks++;
    if (tx_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: pending tx=%0d wr=%0d, want 0 0", tx_q.size(), wr_q.size());
    end
  endtask

  task automatic test_run;
    int starts0;
    starts0 = start_count;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_count != starts0 + 1 || last_start_addr !== 9'h010 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL run_start: starts=%0d addr=%h busy=%b, want 1 010 1",
               start_count - starts0, last_start_addr, bus.busy);
    end
    chk_wr_timing = 1'b0;
    push_wr(12'h066, 8'h77);
    @(posedge clk); #1;
    bus.cpu_raddr = 9'h055; bus.cpu_waddr = 9'h066; bus.cpu_dwrite = 8'h77; bus.cpu_write_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.raddr !== 9'h055 || bus.waddr !== 9'h066 || bus.dwrite !== 8'h77 || bus.write_en !== 1'b1) begin
      errors++;
      $display("FAIL run_ram: got r=%h w=%h d=%h we=%b, want 055 066 77 1",
               bus.raddr, bus.waddr, bus.dwrite, bus.write_en);
    end
    @(posedge clk); #1;
    bus.cpu_write_en = 1'b0;
    bus.rx_byte = 8'h31; bus.received = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_received !== 1'b1) begin
      errors++;
      $display("FAIL run_rx: cpu_received=%b, want 1", bus.cpu_received);
    end
    @(posedge clk); #1;
    bus.received = 1'b0;
    tx_q.push_back(8'h5A);
    bus.cpu_tx_byte = 8'h5A; bus.cpu_transmit = 1'b1;
    @(posedge clk); #1;
    bus.cpu_transmit = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tx_q.push_back(8'h48);
    bus.cpu_halted = 1'b1;
    @(posedge clk); #1;
    bus.cpu_halted = 1'b0;
    wait_drain(100);
    chk_wr_timing = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || wr_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL run_halt: pending tx=%0d wr=%0d busy=%b, want 0 0 0", tx_q.size(), wr_q.size(), bus.busy);
    end
  endtask

  task automatic test_bad_and_dump256;
    int tx0;
    tx_q.push_back(8'h3F);
    @(posedge clk); #1;
    bus.rx_byte = 8'h7A; bus.received = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_received !== 1'b0) begin
      errors++;
      $display("FAIL idle_rx: cpu_received=%b, want 0", bus.cpu_received);
    end
    @(posedge clk); #1;
    bus.received = 1'b0;
    wait_drain(100);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL bad_cmd: pending tx=%0d, want 0", tx_q.size());
    end
    hold_busy = 1'b1;
    tx0 = tx_count;
    for (int i = 0; i < 256; i++) tx_q.push_back(ref_mem[i]);
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_count != tx0) begin
      errors++;
      $display("FAIL hold_busy: got %0d transmits, want 0", tx_count - tx0);
    end
    hold_busy = 1'b0;
    wait_drain(6000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_count - tx0 != 256 || tx_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dump256: got %0d transmits busy=%b, want 256 busy=0", tx_count - tx0, bus.busy);
    end
  endtask

  task automatic test_reset_mid_cmd;
    push_wr(12'h020, 8'hAA);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b pending wr=%0d, want 0 0", bus.busy, wr_q.size());
    end
    tx_q.push_back(8'h3F);
    send_byte(8'hAB);
    wait_drain(100);
    repeat (10) @(posedge clk);
    checks++;
    if (tx_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL rst_after: pending tx=%0d wr=%0d, want 0 0", tx_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_in_run;
    int starts0;
    starts0 = start_count;
    send_byte(8'h52); send_byte(8'h01); send_byte(8'h40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_count != starts0 + 1 || last_start_addr !== 9'h140 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL run2_start: starts=%0d addr=%h busy=%b, want 1 140 1",
               start_count - starts0, last_start_addr, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cpu_startaddr !== '0) begin
      errors++;
      $display("FAIL rst_run: busy=%b startaddr=%h, want 0 000", bus.busy, bus.cpu_startaddr);
    end
    tx_q.push_back(8'h3F);
    send_byte(8'h7A);
    wait_drain(100);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL rst_run_cmd: pending tx=%0d, want 0", tx_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.received = 1'b0; bus.rx_byte = 8'h00; bus.cpu_halted = 1'b0;
    bus.cpu_raddr = '0; bus.cpu_waddr = '0; bus.cpu_dwrite = 8'h00; bus.cpu_write_en = 1'b0;
    bus.cpu_tx_byte = 8'h00; bus.cpu_transmit = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'((i * 7 + 3) & 8'hFF);
      ref_mem[i] = 8'((i * 7 + 3) & 8'hFF);
    end
    test_reset;
    test_load;
    test_dump;
    test_wrap;
    test_run;
    test_bad_and_dump256;
    test_reset_mid_cmd;
    test_reset_in_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule
